// File: rtl/mux_2way_1.sv
// WIDTH-wide 2-to-1 multiplexer leaf; the building block of mux_4way_1.
// An unknown select yields all-X so a bad select is visible rather than masked.
module mux_2way_1 #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel
);

    always_comb begin
        out = {WIDTH{1'bx}};
        case (sel)
            1'b0:    out = a;
            1'b1:    out = b;
            default: out = {WIDTH{1'bx}};
        endcase
    end

endmodule

// File: rtl/mux_4way_1.sv
// 4-to-1 multiplexer built from three 2-to-1 stages, plus a registered copy
// of the selected value for pipeline use. Port order keeps legacy positional use.
module mux_4way_1 #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] out_q
);

    logic [WIDTH-1:0] ab_sel;
    logic [WIDTH-1:0] cd_sel;

    // Stage 1: sel[0] resolves each pair; stage 2: sel[1] picks the pair.
    mux_2way_1 #(.WIDTH(WIDTH)) u_mux_ab (
        .out (ab_sel),
        .a   (a),
        .b   (b),
        .sel (sel[0])
    );

    mux_2way_1 #(.WIDTH(WIDTH)) u_mux_cd (
        .out (cd_sel),
        .a   (c),
        .b   (d),
        .sel (sel[0])
    );

    mux_2way_1 #(.WIDTH(WIDTH)) u_mux_out (
        .out (out),
        .a   (ab_sel),
        .b   (cd_sel),
        .sel (sel[1])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {WIDTH{1'b0}};
        end else begin
            out_q <= out;
        end
    end

endmodule

// File: tb/tb_mux_4way_1.sv
// Directed bench for mux_4way_1: exhaustive 1-bit sweep, 8-bit selection,
// registered path, asynchronous reset and unknown-select behaviour.
module tb_mux_4way_1;

  logic       clk;
  logic       rst_n;

  logic       out1, a1, b1, c1, d1, out_q1;
  logic [1:0] sel1;

  logic [7:0] out8, a8, b8, c8, d8, out_q8;
  logic [1:0] sel8;

  int checks;
  int failures;

  mux_4way_1 #(.WIDTH(1)) dut1 (
    .out   (out1),
    .a     (a1),
    .b     (b1),
    .c     (c1),
    .d     (d1),
    .sel   (sel1),
    .clk   (clk),
    .rst_n (rst_n),
    .out_q (out_q1)
  );

  mux_4way_1 #(.WIDTH(8)) dut8 (
    .out   (out8),
    .a     (a8),
    .b     (b8),
    .c     (c8),
    .d     (d8),
    .sel   (sel8),
    .clk   (clk),
    .rst_n (rst_n),
    .out_q (out_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_tab [4];
    logic [3:0] vec;
    checks   = 0;
    failures = 0;

    rst_n = 1'b0;
    {a1, b1, c1, d1} = 4'b0000;
    sel1 = 2'd0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    sel8 = 2'd0;

    // Reset state
    #3;
    check8("reset_out_q8", out_q8, 8'h00);
    check1("reset_out_q1", out_q1, 1'b0);
    #4 rst_n = 1'b1;

    // Exhaustive 1-bit sweep, each sel held 5 time units
    for (int v = 0; v < 16; v++) begin
      vec = v[3:0];
      {d1, c1, b1, a1} = vec;
      for (int s = 0; s < 4; s++) begin
        sel1 = s[1:0];
        #1;
        check1($sformatf("sweep_v%0d_s%0d", v, s), out1, vec[s]);
        #4;
      end
    end

    // 8-bit selection
    exp_tab[0] = 8'h11; exp_tab[1] = 8'h22; exp_tab[2] = 8'h33; exp_tab[3] = 8'h44;
    for (int s = 0; s < 4; s++) begin
      sel8 = s[1:0];
      #1;
      check8($sformatf("w8_sel%0d", s), out8, exp_tab[s]);
    end

    // Registered path: prior value 8'h11 loaded, then switch to c=A5
    @(negedge clk);
    sel8 = 2'd0;
    @(posedge clk); #1;
    check8("reg_load_a", out_q8, 8'h11);
    @(negedge clk);
    sel8 = 2'd2; c8 = 8'hA5;
    #1;
    check8("reg_comb_a5", out8, 8'hA5);
    check8("reg_hold_prior", out_q8, 8'h11);
    @(posedge clk); #1;
    check8("reg_one_edge", out_q8, 8'hA5);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check8("async_rst_out_q", out_q8, 8'h00);
    check8("async_rst_out", out8, 8'hA5);
    check1("async_rst_out_q1", out_q1, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    check8("rst_release_hold", out_q8, 8'h00);
    check8("rst_release_out", out8, 8'hA5);
    @(posedge clk); #1;
    check8("rst_release_reload", out_q8, 8'hA5);

    // Simultaneous select and data change
    @(negedge clk);
    sel8 = 2'd3; d8 = 8'h5A;
    #1;
    check8("simul_change", out8, 8'h5A);
    @(posedge clk); #1;
    check8("simul_change_q", out_q8, 8'h5A);

    // Unknown select must not resolve to any input (only meaningful in 4-state)
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'hF0;
    sel8 = 2'bx1;
    #1;
    if ($isunknown(sel8)) begin
      check8("sel_x_out", out8, 8'hxx);
    end
    sel8 = 2'd1;
    #1;
    check8("sel_after_x", out8, 8'hF0);

    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
